// File: rtl/alu_sched_if.sv
// Bundle between alu_sched and its surroundings: request channel, the shared ALU, and the tagged response channel.
// The scheduler uses the slave modport. Requesters, the ALU and the response consumer use the master modport.
interface alu_sched_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_src1;
  logic [NUM_REQ*DATA_W-1:0] req_src2;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic                      alu_enable;
  logic [DATA_W-1:0]         alu_src1;
  logic [DATA_W-1:0]         alu_src2;
  logic [OP_W-1:0]           alu_op;
  logic [DATA_W-1:0]         alu_result;
  logic                      alu_overflow;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [ID_W-1:0]           resp_id;
  logic [DATA_W-1:0]         resp_result;
  logic                      resp_overflow;
  logic                      resp_err;

  modport slave (
    input  req_valid, req_src1, req_src2, req_op, alu_result, alu_overflow, resp_ready,
    output req_ready, alu_enable, alu_src1, alu_src2, alu_op,
           resp_valid, resp_id, resp_result, resp_overflow, resp_err
  );

  modport master (
    output req_valid, req_src1, req_src2, req_op, alu_result, alu_overflow, resp_ready,
    input  req_ready, alu_enable, alu_src1, alu_src2, alu_op,
           resp_valid, resp_id, resp_result, resp_overflow, resp_err
  );
endinterface

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one external ALU among NUM_REQ requesters (IDLE -> ISSUE -> RESP).
// Optional ALU_SCHED_OPCHECK_EN: ops above 4'b0101 are not issued and come back with resp_err=1.
//
// Handshakes: a transfer happens on a rising edge where valid && ready. Requesters hold valid and
// payload until ready. resp_id/result/overflow/err hold while resp_valid && !resp_ready.
module alu_sched #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int ID_W    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_sched_if.slave bus,
  output logic       busy,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, id_q, win_id;
  logic [NUM_REQ-1:0]  win_onehot;
  logic                win_found, accept, op_illegal, err_q;
  logic [DATA_W-1:0]   win_src1, win_src2, src1_q, src2_q, result_q;
  logic [OP_W-1:0]     win_op, op_q;
  logic                ovf_q;

  // Search order is rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ; the first valid requester wins.
  always_comb begin
    win_found  = 1'b0;
    win_id     = '0;
    win_onehot = '0;
    win_src1   = '0;
    win_src2   = '0;
    win_op     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && bus.req_valid[i] && ((int'(rr_ptr_q) + k) % NUM_REQ == i)) begin
          win_found     = 1'b1;
          win_id        = ID_W'(i);
          win_onehot[i] = 1'b1;
          win_src1      = bus.req_src1[i*DATA_W +: DATA_W];
          win_src2      = bus.req_src2[i*DATA_W +: DATA_W];
          win_op        = bus.req_op[i*OP_W +: OP_W];
        end
      end
    end
  end

`ifdef ALU_SCHED_OPCHECK_EN
  assign op_illegal = (win_op > OP_W'(5));
`else
  assign op_illegal = 1'b0;
`endif

  assign accept = (state_q == IDLE) && win_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req_ready is gated by rst_n so every output reads 0 while reset is asserted.
  always_comb begin
    bus.req_ready  = (rst_n && state_q == IDLE) ? win_onehot : '0;
    bus.alu_enable = (state_q == ISSUE) && !err_q;
    bus.resp_valid = (state_q == RESP);
    busy           = (state_q != IDLE);
    dbg_state      = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
      id_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      op_q     <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr_q <= win_id;
        id_q     <= win_id;
        src1_q   <= win_src1;
        src2_q   <= win_src2;
        op_q     <= win_op;
        err_q    <= op_illegal;
      end
      if (state_q == ISSUE) begin
        result_q <= err_q ? '0 : bus.alu_result;
        ovf_q    <= err_q ? 1'b0 : bus.alu_overflow;
      end
    end
  end

  // The operand latches drive the ALU directly, so they hold their values outside ISSUE.
  assign bus.alu_src1      = src1_q;
  assign bus.alu_src2      = src2_q;
  assign bus.alu_op        = op_q;
  assign bus.resp_id       = id_q;
  assign bus.resp_result   = result_q;
  assign bus.resp_overflow = ovf_q;
  assign bus.resp_err      = err_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a behavioural ALU (0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 ROTATE).
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_sched;
  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 4;
  localparam int ID_W    = 2;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_SLL = 4'd4;

`ifdef ALU_SCHED_OPCHECK_EN
  localparam logic OPCHK = 1'b1;
`else
  localparam logic OPCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [1:0] dbg_state;
  int         err_cnt = 0;
  int         chk_cnt = 0;
  int         en_total = 0;
  int         en0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_exp;

  alu_sched_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W), .ID_W(ID_W)) bus ();

  alu_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.alu_enable) en_total++;

  // Behavioural ALU; its output is 0 when it is not enabled.
  always_comb begin
    logic [DATA_W-1:0] a, b, r;
    a = bus.alu_src1;
    b = bus.alu_src2;
    r = '0;
    bus.alu_overflow = 1'b0;
    if (bus.alu_enable) begin
      case (bus.alu_op)
        OP_ADD: begin r = a + b; bus.alu_overflow = (a[31] == b[31]) && (r[31] != a[31]); end
        OP_SUB: begin r = a - b; bus.alu_overflow = (a[31] != b[31]) && (r[31] != a[31]); end
        OP_AND: r = a & b;
        OP_OR:  r = a | b;
        OP_SLL: r = a << b[4:0];
        4'd5:   r = (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}));
        default: r = '0;
      endcase
    end
    bus.alu_result = r;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bus.req_src1[i*DATA_W +: DATA_W] = a;
    bus.req_src2[i*DATA_W +: DATA_W] = b;
    bus.req_op[i*OP_W +: OP_W]       = op;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_alu_enable"}, bus.alu_enable, 0);
    check({tag, "_alu_src1"}, bus.alu_src1, 0);
    check({tag, "_alu_src2"}, bus.alu_src2, 0);
    check({tag, "_alu_op"}, bus.alu_op, 0);
    check({tag, "_resp_valid"}, bus.resp_valid, 0);
    check({tag, "_resp_id"}, bus.resp_id, 0);
    check({tag, "_resp_result"}, bus.resp_result, 0);
    check({tag, "_resp_overflow"}, bus.resp_overflow, 0);
    check({tag, "_resp_err"}, bus.resp_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic wait_resp(input string tag, input logic [ID_W-1:0] exp_id, input logic exp_ovf,
                           input logic exp_err);
    int n = 0;
    while (!bus.resp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, bus.resp_valid, 1);
    last_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_id"}, bus.resp_id, exp_id);
    check({tag, "_result"}, bus.resp_result, last_exp);
    check({tag, "_overflow"}, bus.resp_overflow, exp_ovf);
    check({tag, "_err"}, bus.resp_err, exp_err);
    check({tag, "_state"}, dbg_state, 2);
  endtask

  task automatic ack(input string tag, input int hold);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, bus.resp_valid, 1);
      check({tag, "_hold_result"}, bus.resp_result, last_exp);
      check({tag, "_hold_rdy"}, bus.req_ready, 0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({tag, "_drop_valid"}, bus.resp_valid, 0);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b1;
    bus.req_valid  = '0;
    bus.req_src1   = '0;
    bus.req_src2   = '0;
    bus.req_op     = '0;
    bus.resp_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Single request: 21 + 46
    set_req(0, 21, 46, OP_ADD);
    bus.req_valid = 2'b01;
    exp_q.push_back(32'h0000_0043);
    en0 = en_total;
    #1 check("t1_rdy", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req_valid = 2'b00;
    check("t1_rdy_issue", bus.req_ready, 0);
    check("t1_en", bus.alu_enable, 1);
    check("t1_src1", bus.alu_src1, 21);
    check("t1_src2", bus.alu_src2, 46);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_latency", bus.resp_valid, 1);
    check("t1_en_off", bus.alu_enable, 0);
    wait_resp("t1", 0, 0, 0);
    ack("t1", 0);
    check("t1_en_cnt", en_total - en0, 1);

    // Backpressure on req1 SUB while req0 waits with an overflowing ADD
    set_req(1, 648, 1035, OP_SUB);
    bus.req_valid = 2'b10;
    exp_q.push_back(32'hFFFF_FE7D);
    #1 check("t2_rdy", bus.req_ready, 2'b10);
    @(negedge clk);
    set_req(0, 32'h7FFF_FFFF, 32'h1, OP_ADD);
    bus.req_valid = 2'b01;
    check("t2_rdy_issue", bus.req_ready, 0);
    @(negedge clk);
    wait_resp("t2", 1, 0, 0);
    ack("t2", 5);
    exp_q.push_back(32'h8000_0000);
    check("t3_rdy", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    wait_resp("t3", 0, 1, 0);
    ack("t3", 0);

    // Reset while a response is pending
    set_req(1, 3, 5, OP_OR);
    bus.req_valid = 2'b10;
    exp_q.push_back(32'h0000_0007);
    #1 check("t4_rdy", bus.req_ready, 2'b10);
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    wait_resp("t4", 1, 0, 0);
    rst_n = 1'b0;
    #1 check_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t4_post_busy", busy, 0);
    check("t4_post_valid", bus.resp_valid, 0);
    @(negedge clk);
    check("t4_post_valid2", bus.resp_valid, 0);

    // Contention: both valid after reset, requester 0 first
    set_req(0, 12356, 3, OP_SLL);
    set_req(1, 1034, 3028, OP_AND);
    bus.req_valid = 2'b11;
    exp_q.push_back(32'h0001_8220);
    #1 check("t5a_rdy", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req_valid = 2'b10;
    @(negedge clk);
    wait_resp("t5a", 0, 0, 0);
    ack("t5a", 1);
    exp_q.push_back(32'h0000_0000);
    check("t5b_rdy", bus.req_ready, 2'b10);
    set_req(0, 32'hF0, 32'h0F, OP_OR);
    bus.req_valid = 2'b11;
    #1 check("t5b_rdy_both", bus.req_ready, 2'b10);
    @(negedge clk);
    bus.req_valid = 2'b01;
    @(negedge clk);
    wait_resp("t5b", 1, 0, 0);
    ack("t5b", 0);
    exp_q.push_back(32'h0000_00FF);
    check("t5c_rdy", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    wait_resp("t5c", 0, 0, 0);
    ack("t5c", 0);

    // Opcode outside the ALU set
    set_req(0, 5, 6, 4'hF);
    bus.req_valid = 2'b01;
    exp_q.push_back(32'h0000_0000);
    en0 = en_total;
    #1 check("t6_rdy", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req_valid = 2'b00;
    check("t6_en", bus.alu_enable, !OPCHK);
    @(negedge clk);
    wait_resp("t6", 0, 0, OPCHK);
    ack("t6", 0);
    check("t6_en_cnt", en_total - en0, OPCHK ? 0 : 1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
